// File: rtl/logic_op_pkg.sv
// Shared opcode encodings for the pipelined bitwise logic unit.
package logic_op_pkg;

    typedef logic [2:0] op_t;

    // Codes 000-011 keep the legacy {s1,s0} selector encoding.
    localparam op_t OP_XOR    = 3'b000;
    localparam op_t OP_NOR    = 3'b001;
    localparam op_t OP_NAND   = 3'b010;
    localparam op_t OP_ZERO   = 3'b011;
    localparam op_t OP_AND    = 3'b100;
    localparam op_t OP_OR     = 3'b101;
    localparam op_t OP_XNOR   = 3'b110;
    localparam op_t OP_PASS_A = 3'b111;

endpackage

// File: rtl/logic_op_lane.sv
// Combinational bitwise operation for one WIDTH-bit operand pair.
module logic_op_lane
    import logic_op_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y
);

    // Opcode decode; purely bitwise, no carries between lanes.
    always_comb begin
        y = '0;
        unique case (op)
            OP_XOR:    y = a ^ b;
            OP_NOR:    y = ~(a | b);
            OP_NAND:   y = ~(a & b);
            OP_ZERO:   y = '0;
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XNOR:   y = ~(a ^ b);
            OP_PASS_A: y = a;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready bitwise logic pipeline with accumulator chaining
// and a completed-transaction counter.
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2:0]           in_op,
    input  logic                 in_acc,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [WIDTH-1:0]     acc_value,
    output logic [CNT_WIDTH-1:0] done_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_t              s1_op;
    logic             s1_acc;

    logic             s2_load;
    logic             in_fire;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;

    // Stage advance conditions; in_ready follows out_ready combinationally.
    always_comb begin
        s2_load  = s1_valid & (~out_valid | out_ready);
        in_ready = ~s1_valid | s2_load;
        in_fire  = in_valid & in_ready;
        // Accumulator operand is read at the S1->S2 edge, so a back-to-back
        // acc-mode transaction sees the previous result without a stall.
        op_a     = s1_acc ? acc_value : s1_a;
    end

    logic_op_lane #(.WIDTH(WIDTH)) u_lane (
        .a  (op_a),
        .b  (in_b_s1()),
        .op (s1_op),
        .y  (result)
    );

    function automatic logic [WIDTH-1:0] in_b_s1();
        return s1_b;
    endfunction

    // Stage 1 operand register, loaded on input handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_XOR;
            s1_acc   <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= op_t'(in_op);
            s1_acc   <= in_acc;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 result register; a new result replaces a consumed one with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_data  <= result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator: clear wins over a coincident acc-mode load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_value <= '0;
        end else if (acc_clr) begin
            acc_value <= '0;
        end else if (s2_load && s1_acc) begin
            acc_value <= result;
        end
    end

    // Completed output handshakes, wrapping at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_count <= '0;
        end else if (out_valid && out_ready) begin
            done_count <= done_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed self-checking bench for logic_op_pipe.
module tb_logic_op_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [2:0]  in_op;
    logic        in_acc;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [7:0]  acc_value;
    logic [15:0] done_count;

    logic        in_ready2;
    logic        out_valid2;
    logic [7:0]  out_data2;
    logic [7:0]  acc_value2;
    logic [1:0]  done_count2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic_op_pipe #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .acc_value  (acc_value),
        .done_count (done_count)
    );

    logic_op_pipe #(.WIDTH(8), .CNT_WIDTH(2)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .out_data   (out_data2),
        .acc_value  (acc_value2),
        .done_count (done_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic acc);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_acc   = acc;
    endtask

    logic [7:0] exp1 [4] = '{8'h7C, 8'h80, 8'hFC, 8'h00};
    logic [2:0] ops2 [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [7:0] exp2 [7] = '{8'hCC, 8'h12, 8'hDE, 8'h21, 8'hED, 8'h33, 8'h69};

    initial begin
        rst = 1'b1;
        acc_clr = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_acc", 32'(acc_value), 32'd0);
        check("rst_count", 32'(done_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Legacy ops, a=0x77 b=0x0B
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h77, 8'h0B, 3'(i), 1'b0);
            tick();
            if (i >= 1) check("legacy_data", 32'(out_data), 32'(exp1[i-1]));
        end
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        tick();
        check("legacy_data_last", 32'(out_data), 32'(exp1[3]));
        check("legacy_valid_last", 32'(out_valid), 32'd1);
        tick();
        check("legacy_drained", 32'(out_valid), 32'd0);
        check("legacy_count", 32'(done_count), 32'd4);

        // All ops back-to-back, a=0x69 b=0xA5
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'h69, 8'hA5, ops2[i], 1'b0);
            #1;
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (i >= 1) check("b2b_data", 32'(out_data), 32'(exp2[i-1]));
        end
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        tick();
        check("b2b_data_last", 32'(out_data), 32'(exp2[6]));
        tick();
        check("b2b_count", 32'(done_count), 32'd11);

        // Accumulator chain
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("acc_cleared", 32'(acc_value), 32'd0);
        drive(1'b1, 8'hAA, 8'h0F, 3'b000, 1'b1);
        tick();
        drive(1'b1, 8'hAA, 8'hFF, 3'b000, 1'b1);
        tick();
        check("acc_r0", 32'(out_data), 32'h0F);
        drive(1'b1, 8'hAA, 8'h01, 3'b101, 1'b1);
        tick();
        check("acc_r1", 32'(out_data), 32'hF0);
        drive(1'b1, 8'h00, 8'hFF, 3'b100, 1'b0);
        tick();
        check("acc_r2", 32'(out_data), 32'hF1);
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        tick();
        check("acc_r3_nonacc", 32'(out_data), 32'h00);
        check("acc_held", 32'(acc_value), 32'hF1);
        tick();
        check("acc_count", 32'(done_count), 32'd15);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 3'b000, 1'b0);
        tick();
        drive(1'b1, 8'hF0, 8'h0F, 3'b101, 1'b0);
        #1;
        check("bp_ready_second", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 8'hF0, 8'h3C, 3'b100, 1'b0);
        #1;
        check("bp_ready_full", 32'(in_ready), 32'd0);
        check("bp_data_a", 32'(out_data), 32'h33);
        tick();
        check("bp_stable_data", 32'(out_data), 32'h33);
        check("bp_stable_valid", 32'(out_valid), 32'd1);
        check("bp_stable_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        check("bp_data_b", 32'(out_data), 32'hFF);
        tick();
        check("bp_data_c", 32'(out_data), 32'h30);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_count", 32'(done_count), 32'd18);

        // acc_clr coincident with acc-mode transfer
        drive(1'b1, 8'h00, 8'h01, 3'b000, 1'b1);
        tick();
        drive(1'b1, 8'h00, 8'h0F, 3'b000, 1'b1);
        tick();
        check("clr_pre_data", 32'(out_data), 32'hF0);
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("clr_data", 32'(out_data), 32'hFF);
        check("clr_acc", 32'(acc_value), 32'h00);
        tick();
        check("clr_count", 32'(done_count), 32'd20);

        // Reset with both stages full
        out_ready = 1'b0;
        drive(1'b1, 8'h00, 8'h5A, 3'b000, 1'b1);
        tick();
        drive(1'b1, 8'h12, 8'h34, 3'b101, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_acc", 32'(acc_value), 32'h5A);
        check("full_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_data", 32'(out_data), 32'd0);
        check("async_acc", 32'(acc_value), 32'd0);
        check("async_count", 32'(done_count), 32'd0);
        check("async_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_count", 32'(done_count), 32'd0);

        // Counter wrap: 5 handshakes
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i), 8'h01, 3'b000, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        tick();
        tick();
        check("wrap_count16", 32'(done_count), 32'd5);
        check("wrap_count2", 32'(done_count2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_op_pipe.md
# logic_op_pipe

Parametrised, pipelined bitwise logic unit; generational successor of the 8-bit XOR/NOR/NAND selector. Applies one of eight bitwise operations to two WIDTH-bit operands per transaction. Adds valid/ready flow control, a two-stage pipeline, an accumulator mode that chains results, and a completed-transaction counter. Sits between an operand source and a result consumer in the datapath.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_WIDTH, 16, width of done_count
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- in_valid  in  1  operand transaction offered
- in_ready  out  1  block accepts transaction this cycle
- in_a  in  WIDTH  operand A; ignored when in_acc=1
- in_b  in  WIDTH  operand B
- in_op  in  3  operation code
- in_acc  in  1  1: use accumulator as operand A
- acc_clr  in  1  synchronous accumulator clear pulse
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- acc_value  out  WIDTH  current accumulator contents
- done_count  out  CNT_WIDTH  completed output handshakes

## Operation
- Opcodes: 000 XOR, 001 NOR, 010 NAND, 011 ZERO (all-zero, matches legacy s1s0=11 output), 100 AND, 101 OR, 110 XNOR, 111 PASS_A. Codes 000–011 are bit-compatible with the legacy {s1,s0} select.
- Stage 1 (S1): registers in_a, in_b, in_op, in_acc on input handshake (in_valid & in_ready).
- Stage 2 (S2): on S1→S2 transfer, result = op(A', in_b), with A' = acc if S1.acc else S1.a; the result loads into out_data.
- Accumulator: loads the result on every S1→S2 transfer whose S1.acc=1; unchanged otherwise. Transfers without acc do not touch it.
- acc_clr: acc←0 next edge. If coincident with an acc-mode transfer: the transfer computes with old acc, the result goes to out_data, and the clear wins for acc.
- done_count increments on out_valid & out_ready; wraps to 0 after all-ones.
- All arithmetic is purely bitwise, width WIDTH; no carries.

## Timing
- Reset (async assert, sync-release safe): out_valid=0, in_ready=1 after reset, out_data=0, acc_value=0, done_count=0, S1/S2 valids=0. A transaction in flight at reset is discarded; no partial result emerges.
- S2 advance: s2_load = s1_valid & (!out_valid | out_ready).
- S1 advance: in_ready = !s1_valid | s2_load (combinational from out_ready; no registered skid).
- Latency: handshake at edge N → out_valid high after edge N+1, data valid same cycle.
- Throughput: one transaction per cycle with out_ready held high.
- Backpressure: with out_ready low, two transactions are held (S1, S2); in_ready drops after the second acceptance. out_data and out_valid are stable while out_valid & !out_ready.
- Simultaneous output handshake and S1→S2 load: the new result replaces the old one in the same edge, with no bubble.
- Back-to-back acc-mode transactions see the previous acc-mode result without stall; the dependency resolves at the S1→S2 edge.
- acc_value is registered and reflects updates one edge after the transfer.

## Structure
- Package logic_op_pkg: opcode localparams (OP_XOR … OP_PASS_A) and the 3-bit op type.
- Sub-module logic_op_lane: combinational WIDTH-parametrised op decode and result (in: a, b, op; out: y). Instantiated once in S2 compute.
- Top holds the S1/S2 registers, the handshake, the accumulator and the counter.

## Test plan
- WIDTH=8, out_ready=1, a=0x77 b=0x0B, ops 000/001/010/011 → out_data 0x7C, 0x80, 0xFC, 0x00, each 2 cycles after acceptance; done_count=4.
- a=0x69 b=0xA5, ops 000/001/010/100/101/110/111 back-to-back → 0xCC, 0x12, 0xDE, 0x21, 0xED, 0x33, 0x69 on consecutive cycles.
- Accumulator: acc_clr; in_acc=1 XOR b=0x0F → 0x0F; XOR b=0xFF → 0xF0; OR b=0x01 → 0xF1; non-acc AND a=0x00 → 0x00 and acc_value stays 0xF1. Sent back-to-back with no stall.
- Backpressure: out_ready=0, offer 3 transactions → first 2 accepted, in_ready=0. Release out_ready → results emerge in order, third accepted, out_data stable while stalled.
- acc_clr coincident with acc-mode transfer (acc=0xF0, XOR b=0x0F) → out_data 0xFF, acc_value 0x00.
- Assert rst with S1 and S2 full → all outputs reset values immediately. After release, no stale out_valid; done_count=0. Wrap check with CNT_WIDTH=2: 5 handshakes → done_count=1.
